// File: rtl/serial_comparator.sv
`timescale 1ns/1ps
// serial_comparator: bit-serial magnitude compare of two unsigned operands.
// Operands are captured on a valid/ready handshake, then walked MSB first,
// one bit per clock. The result (g = A>B, l = A<B) is held on a
// valid/ready output until the consumer takes it. With EARLY_EXIT the walk
// stops at the first differing bit; otherwise all WIDTH bits are scanned.
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g,
    output logic             l
);

    // Counter only has to hold WIDTH-1.
    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               g_q, g_d;
    logic               l_q, l_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               a_bit;
    logic               b_bit;
    logic               bits_differ;

    // Next-state, datapath and handshake-flag logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        g_d         = g_q;
        l_d         = l_q;
        a_bit       = 1'b0;
        b_bit       = 1'b0;
        bits_differ = 1'b0;

        case (state_q)
            IDLE: begin
                // in_ready_q is low for the first IDLE cycle after reset,
                // so the handshake is qualified with the registered flag.
                if (in_valid && in_ready_q) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = CNT_LOAD;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_bit       = a_q[WIDTH-1];
                b_bit       = b_q[WIDTH-1];
                bits_differ = (a_bit != b_bit);

                // Only the first difference decides the result; once g or l
                // is latched, lower-order bits cannot override it.
                if (bits_differ && !(g_q || l_q)) begin
                    g_d = a_bit;
                    l_d = b_bit;
                end

                a_d = {a_q[WIDTH-2:0], 1'b0};
                b_d = {b_q[WIDTH-2:0], 1'b0};
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end

                if ((EARLY_EXIT && bits_differ) || (cnt_q == '0)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            g_q         <= 1'b0;
            l_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            l_q         <= l_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign g         = g_q;
    assign l         = l_q;

endmodule
